prio_case_reg: RTL

// Registered, latch-free successor to the combinational if/else-if and case selectors.
// - Maps operand pair {a,b} to a 1-bit decision in one of two modes:
//   - priority scan over bit lanes, or
//   - programmable case table with an explicit miss policy.
// - Every path is fully specified. Hold is an explicit flop, never an inferred latch.
// - Sits between operand producers and decision consumers, with valid/ready on both sides.

---
 rtl/prio_case_reg.sv | 131 +++++++++++++
 1 files changed

// File: rtl/prio_case_reg.sv
// rtl/prio_case_reg.sv - registered priority-scan / programmable case-table decision stage
//
// Ports:
//   clk, rst_n                 rising-edge clock, synchronous active-low reset
//   mode                       0 = priority lane scan, 1 = case-table lookup (per beat)
//   in_valid, in_ready, a, b   operand beat; accepted when in_valid & in_ready
//   out_valid, out_ready       result handshake
//   out, hit, hit_idx          registered decision, match flag, winning lane/entry
//   cfg_we, cfg_idx,
//   cfg_key, cfg_val           case-table entry write port
//   miss_cnt                   saturating count of accepted beats that missed
module prio_case_reg #(
    parameter int       WIDTH        = 4,
    parameter int       NENT         = 4,
    parameter int       IDX_W        = 2,
    parameter bit       HOLD_ON_MISS = 1'b1,
    parameter bit       DEF_VAL      = 1'b0,
    parameter int       CNT_W        = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out,
    output logic                 hit,
    output logic [IDX_W-1:0]     hit_idx,
    input  logic                 cfg_we,
    input  logic [IDX_W-1:0]     cfg_idx,
    input  logic [2*WIDTH-1:0]   cfg_key,
    input  logic                 cfg_val,
    output logic [CNT_W-1:0]     miss_cnt
);

    logic [NENT-1:0]    ent_vld;
    logic [2*WIDTH-1:0] ent_key [NENT];
    logic               ent_val [NENT];

    logic               accept;
    logic               p_hit, p_out;
    logic [IDX_W-1:0]   p_idx;
    logic               c_hit, c_out;
    logic [IDX_W-1:0]   c_idx;
    logic               sel_hit, sel_out;
    logic [IDX_W-1:0]   sel_idx;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Scan from the top down so the lowest qualifying lane is the last write and wins.
    always_comb begin
        p_hit = 1'b0;
        p_out = 1'b0;
        p_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (a[i] || b[i]) begin
                p_hit = 1'b1;
                p_out = a[i] && b[i];
                p_idx = IDX_W'(i);
            end
        end
    end

    // Same top-down trick: lowest matching valid entry wins. Reads the registered
    // table, so a write in the same cycle is not yet visible.
    always_comb begin
        c_hit = 1'b0;
        c_out = 1'b0;
        c_idx = '0;
        for (int e = NENT - 1; e >= 0; e--) begin
            if (ent_vld[e] && (ent_key[e] == {a, b})) begin
                c_hit = 1'b1;
                c_out = ent_val[e];
                c_idx = IDX_W'(e);
            end
        end
    end

    always_comb begin
        sel_hit = mode ? c_hit : p_hit;
        sel_idx = mode ? c_idx : p_idx;
        if (sel_hit) begin
            sel_out = mode ? c_out : p_out;
        end else begin
            sel_out = HOLD_ON_MISS ? out : DEF_VAL;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= 1'b0;
            hit       <= 1'b0;
            hit_idx   <= '0;
            miss_cnt  <= '0;
            ent_vld   <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out       <= sel_out;
                hit       <= sel_hit;
                hit_idx   <= sel_hit ? sel_idx : '0;
                if (!sel_hit && (miss_cnt != {CNT_W{1'b1}})) begin
                    miss_cnt <= miss_cnt + CNT_W'(1);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            for (int e = 0; e < NENT; e++) begin
                if (cfg_we && (cfg_idx == IDX_W'(e))) begin
                    ent_vld[e] <= 1'b1;
                end
            end
        end
    end

    // Keys and values carry no reset; the valid bits alone gate them.
    always_ff @(posedge clk) begin
        for (int e = 0; e < NENT; e++) begin
            if (cfg_we && (cfg_idx == IDX_W'(e))) begin
                ent_key[e] <= cfg_key;
                ent_val[e] <= cfg_val;
            end
        end
    end

endmodule
